uart_boot_loader: RTL and testbench

//  Serial firmware loader: receives a framed image over UART RX, writes it word-by-word into
//  the CPU's instruction/RAM write port, and holds the CPU in reset until the image is verified.

---
 rtl/uart_boot_loader_pkg.sv | 24 ++
 rtl/synchronizer.sv | 26 ++
 rtl/uart_rx_byte.sv | 88 ++++++++
 rtl/uart_boot_loader.sv | 171 +++++++++++++++++
 tb/tb_uart_boot_loader.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_boot_loader_pkg.sv
// Shared constants and state types for the UART boot loader.
// Imported by uart_rx_byte and uart_boot_loader.
package uart_boot_loader_pkg;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    DATA,
    CHK,
    DONE,
    ERROR
  } ldr_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/synchronizer.sv
// Multi-stage flop synchronizer for asynchronous inputs.
// Ports: sysClk, sysRes (async, active-low), d in, q out.
module synchronizer #(
  parameter int             LEN     = 1,
  parameter int             STAGES  = 2,
  parameter logic [LEN-1:0] RST_VAL = '0
) (
  input  logic           sysClk,
  input  logic           sysRes,
  input  logic [LEN-1:0] d,
  output logic [LEN-1:0] q
);

  logic [STAGES-1:0][LEN-1:0] ff;

  always_ff @(posedge sysClk or negedge sysRes) begin
    if (!sysRes) begin
      ff <= {STAGES{RST_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver, DIV sysClk cycles per bit.
// Ports: sysClk, sysRes, rxIn (synchronized), byteOut, byteValid, frameErr.
module uart_rx_byte
  import uart_boot_loader_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       sysClk,
  input  logic       sysRes,
  input  logic       rxIn,
  output logic [7:0] byteOut,
  output logic       byteValid,
  output logic       frameErr
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  rx_state_t   state, stateN;
  logic [CW-1:0] cnt, cntN;
  logic [2:0]  bitIdx, bitN;
  logic [7:0]  sh, shN;
  logic        vN, eN;
  logic        rxPrev;

  always_ff @(posedge sysClk or negedge sysRes) begin
    if (!sysRes) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bitIdx    <= '0;
      sh        <= '0;
      byteValid <= 1'b0;
      frameErr  <= 1'b0;
      rxPrev    <= 1'b1;
    end else begin
      state     <= stateN;
      cnt       <= cntN;
      bitIdx    <= bitN;
      sh        <= shN;
      byteValid <= vN;
      frameErr  <= eN;
      rxPrev    <= rxIn;
    end
  end

  always_comb begin
    stateN = state;
    cntN   = cnt + 1'b1;
    bitN   = bitIdx;
    shN    = sh;
    vN     = 1'b0;
    eN     = 1'b0;
    unique case (state)
      RX_IDLE: begin
        cntN = '0;
        // start only on a real high-to-low edge
        if (rxPrev && !rxIn) stateN = RX_START;
      end
      RX_START: begin
        if (cnt == HALF) begin
          cntN   = '0;
          bitN   = '0;
          stateN = rxIn ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == LAST) begin
          cntN = '0;
          shN  = {rxIn, sh[7:1]};
          bitN = bitIdx + 3'd1;
          if (bitIdx == 3'd7) stateN = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == LAST) begin
          stateN = RX_IDLE;
          vN     = rxIn;
          eN     = !rxIn;
        end
      end
      default: stateN = RX_IDLE;
    endcase
  end

  assign byteOut = sh;

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a framed firmware image from UART into memory; holds CPU in reset until verified.
// Ports: sysClk, sysRes, rxd in; memWe/memAddr/memWData, cpuRes, loadDone, loadErr out.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int ADDR_WIDTH = 12,
  parameter int START_ADDR = 0
) (
  input  logic                  sysClk,
  input  logic                  sysRes,
  input  logic                  rxd,
  output logic                  memWe,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [31:0]           memWData,
  output logic                  cpuRes,
  output logic                  loadDone,
  output logic                  loadErr
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam logic [16:0] MAX_CNT = 17'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(START_ADDR);

  logic       rxS;
  logic [7:0] rxByte;
  logic       byteValid, frameErr;

  synchronizer #(
    .LEN    (1),
    .STAGES (2),
    .RST_VAL(1'b1)
  ) u_sync (
    .sysClk(sysClk),
    .sysRes(sysRes),
    .d     (rxd),
    .q     (rxS)
  );

  uart_rx_byte #(
    .DIV(DIV)
  ) u_rx (
    .sysClk   (sysClk),
    .sysRes   (sysRes),
    .rxIn     (rxS),
    .byteOut  (rxByte),
    .byteValid(byteValid),
    .frameErr (frameErr)
  );

  ldr_state_t            state, stateN;
  logic [15:0]           cnt, cntN;
  logic [15:0]           wordIdx, wordIdxN;
  logic [1:0]            byteIdx, byteIdxN;
  logic [23:0]           wbuf, wbufN;
  logic [7:0]            xsum, xsumN;
  logic                  weN, doneN, errN;
  logic [ADDR_WIDTH-1:0] addrN;
  logic [31:0]           wdN;
  logic [15:0]           fullCnt;

  always_ff @(posedge sysClk or negedge sysRes) begin
    if (!sysRes) begin
      state    <= IDLE;
      cnt      <= '0;
      wordIdx  <= '0;
      byteIdx  <= '0;
      wbuf     <= '0;
      xsum     <= '0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWData <= '0;
      loadDone <= 1'b0;
      loadErr  <= 1'b0;
    end else begin
      state    <= stateN;
      cnt      <= cntN;
      wordIdx  <= wordIdxN;
      byteIdx  <= byteIdxN;
      wbuf     <= wbufN;
      xsum     <= xsumN;
      memWe    <= weN;
      memAddr  <= addrN;
      memWData <= wdN;
      loadDone <= doneN;
      loadErr  <= errN;
    end
  end

  assign fullCnt = {rxByte, cnt[7:0]};

  always_comb begin
    stateN   = state;
    cntN     = cnt;
    wordIdxN = wordIdx;
    byteIdxN = byteIdx;
    wbufN    = wbuf;
    xsumN    = xsum;
    weN      = 1'b0;
    addrN    = memAddr;
    wdN      = memWData;
    doneN    = loadDone;
    errN     = loadErr;
    if (frameErr && state != DONE) begin
      // a bad stop bit also drops a word completed by that byte
      stateN = ERROR;
      errN   = 1'b1;
    end else if (byteValid) begin
      unique case (state)
        IDLE, ERROR: begin
          if (rxByte == LOADER_SYNC_BYTE) begin
            stateN   = CNT_LO;
            errN     = 1'b0;
            cntN     = '0;
            wordIdxN = '0;
            byteIdxN = '0;
            wbufN    = '0;
            xsumN    = '0;
          end
        end
        CNT_LO: begin
          cntN[7:0] = rxByte;
          stateN    = CNT_HI;
        end
        CNT_HI: begin
          cntN[15:8] = rxByte;
          if ({1'b0, fullCnt} > MAX_CNT) begin
            stateN = ERROR;
            errN   = 1'b1;
          end else if (fullCnt == 16'd0) begin
            stateN = CHK;
          end else begin
            stateN = DATA;
          end
        end
        DATA: begin
          xsumN = xsum ^ rxByte;
          unique case (byteIdx)
            2'd0: wbufN[7:0]   = rxByte;
            2'd1: wbufN[15:8]  = rxByte;
            2'd2: wbufN[23:16] = rxByte;
            default: begin
              weN      = 1'b1;
              wdN      = {rxByte, wbuf};
              addrN    = BASE + wordIdx[ADDR_WIDTH-1:0];
              wordIdxN = wordIdx + 16'd1;
              if (wordIdx == cnt - 16'd1) stateN = CHK;
            end
          endcase
          byteIdxN = byteIdx + 2'd1;
        end
        CHK: begin
          if (rxByte == xsum) begin
            stateN = DONE;
            doneN  = 1'b1;
          end else begin
            stateN = ERROR;
            errN   = 1'b1;
          end
        end
        DONE: stateN = DONE;
        default: stateN = IDLE;
      endcase
    end
  end

  // CPU only runs once a checksum-verified image is in memory
  assign cpuRes = !loadDone;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: random frames, two address bases.
// Stimulus pushes expected writes; a negedge monitor pops and compares.
module tb_uart_boot_loader;

  localparam int DIV = 10;

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        rxd      [2];
  logic        memWe    [2];
  logic [11:0] memAddr  [2];
  logic [31:0] memWData [2];
  logic        cpuRes   [2];
  logic        loadDone [2];
  logic        loadErr  [2];

  int checks;
  int failures;
  wr_t expQ0[$];
  wr_t expQ1[$];
  logic [31:0] img[$];
  logic prevWe [2];

  uart_boot_loader #(
    .CLK_FREQ(1_000_000), .BAUD(100_000),
    .ADDR_WIDTH(12), .START_ADDR(0)
  ) dut0 (
    .sysClk(clk), .sysRes(rst_n), .rxd(rxd[0]),
    .memWe(memWe[0]), .memAddr(memAddr[0]),
    .memWData(memWData[0]), .cpuRes(cpuRes[0]),
    .loadDone(loadDone[0]), .loadErr(loadErr[0])
  );

  uart_boot_loader #(
    .CLK_FREQ(1_000_000), .BAUD(100_000),
    .ADDR_WIDTH(12), .START_ADDR(4094)
  ) dut1 (
    .sysClk(clk), .sysRes(rst_n), .rxd(rxd[1]),
    .memWe(memWe[1]), .memAddr(memAddr[1]),
    .memWData(memWData[1]), .cpuRes(cpuRes[1]),
    .loadDone(loadDone[1]), .loadErr(loadErr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: every write must match the head of the expected queue
  always @(negedge clk) begin
    wr_t e;
    logic have;
    for (int s = 0; s < 2; s++) begin
      if (memWe[s]) begin
        have = 1'b0;
        if (s == 0 && expQ0.size() > 0) begin
          e = expQ0.pop_front();
          have = 1'b1;
        end
        if (s == 1 && expQ1.size() > 0) begin
          e = expQ1.pop_front();
          have = 1'b1;
        end
        checks++;
        if (!have) begin
          failures++;
          $display("FAIL unexpected_write dut%0d actual addr=%0d data=%h required none",
                   s, memAddr[s], memWData[s]);
        end else if (memAddr[s] !== e.a || memWData[s] !== e.d) begin
          failures++;
          $display("FAIL write dut%0d actual %0d:%h required %0d:%h",
                   s, memAddr[s], memWData[s], e.a, e.d);
        end
        checks++;
        if (prevWe[s]) begin
          failures++;
          $display("FAIL we_back_to_back dut%0d actual 2 cycles required 1", s);
        end
      end
      prevWe[s] = memWe[s];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int s, input int w, input logic [31:0] d);
    wr_t e;
    e.a = 12'((s == 0 ? 0 : 4094) + w);
    e.d = d;
    if (s == 0) expQ0.push_back(e);
    else expQ1.push_back(e);
  endtask

  task automatic send_byte(input int s, input logic [7:0] b, input logic badStop);
    rxd[s] = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd[s] = b[i];
      tick(DIV);
    end
    rxd[s] = !badStop;
    tick(DIV);
    rxd[s] = 1'b1;
    tick(3);
  endtask

  task automatic glitch(input int s);
    rxd[s] = 1'b0;
    tick(4);
    rxd[s] = 1'b1;
    tick(3 * DIV);
  endtask

  // frame from img[]; badIdx/glitchIdx index the data bytes (-1 = none)
  task automatic send_frame(input int s, input logic [15:0] cnt,
                            input logic flip, input int badIdx,
                            input int glitchIdx);
    logic [7:0] x;
    logic [7:0] b;
    int idx;
    x = 8'h00;
    send_byte(s, 8'hA5, 1'b0);
    send_byte(s, cnt[7:0], 1'b0);
    send_byte(s, cnt[15:8], 1'b0);
    for (int w = 0; w < int'(cnt); w++) begin
      for (int k = 0; k < 4; k++) begin
        idx = 4 * w + k;
        b = img[w][8*k +: 8];
        if (idx == glitchIdx) glitch(s);
        if (idx == badIdx) begin
          send_byte(s, b, 1'b1);
          return;
        end
        x ^= b;
        if (k == 3) push_exp(s, w, img[w]);
        send_byte(s, b, 1'b0);
      end
    end
    chk("cpuRes_before_chk", 32'(cpuRes[s]), 32'd1);
    send_byte(s, x ^ {7'b0, flip}, 1'b0);
  endtask

  task automatic expect_end(input int s, input string name,
                            input logic done, input logic err);
    tick(20);
    chk({name, "_done"}, 32'(loadDone[s]), 32'(done));
    chk({name, "_err"}, 32'(loadErr[s]), 32'(err));
    chk({name, "_cpuRes"}, 32'(cpuRes[s]), 32'(!done));
    chk({name, "_drain"}, (s == 0) ? expQ0.size() : expQ1.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    expQ0.delete();
    expQ1.delete();
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic rand_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  initial begin
    int n;
    int bad;
    int s;
    logic flip;
    logic [7:0] g;
    checks = 0;
    failures = 0;
    rxd[0] = 1'b1;
    rxd[1] = 1'b1;
    prevWe[0] = 1'b0;
    prevWe[1] = 1'b0;
    rst_n = 1'b0;
    tick(2);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_we", 32'(memWe[i]), 32'd0);
      chk("rst_addr", 32'(memAddr[i]), 32'd0);
      chk("rst_wdata", memWData[i], 32'd0);
      chk("rst_cpuRes", 32'(cpuRes[i]), 32'd1);
      chk("rst_done", 32'(loadDone[i]), 32'd0);
      chk("rst_err", 32'(loadErr[i]), 32'd0);
    end
    do_reset();

    // known two-word image
    img = '{32'h00000013, 32'h00100093};
    send_frame(0, 16'd2, 1'b0, -1, -1);
    expect_end(0, "t1", 1'b1, 1'b0);

    // bad checksum, then retry
    do_reset();
    send_frame(0, 16'd2, 1'b1, -1, -1);
    expect_end(0, "t2_bad", 1'b0, 1'b1);
    send_frame(0, 16'd2, 1'b0, -1, -1);
    expect_end(0, "t2_retry", 1'b1, 1'b0);

    // leading junk ignored, empty image accepted
    do_reset();
    send_byte(0, 8'h00, 1'b0);
    send_byte(0, 8'hFF, 1'b0);
    send_byte(0, 8'h3C, 1'b0);
    expect_end(0, "t3_junk", 1'b0, 1'b0);
    send_frame(0, 16'd0, 1'b0, -1, -1);
    expect_end(0, "t3_empty", 1'b1, 1'b0);

    // framing error on 2nd data byte
    do_reset();
    rand_img(2);
    send_frame(0, 16'd2, 1'b0, 1, -1);
    expect_end(0, "t4_frame", 1'b0, 1'b1);

    // short low glitch between data bytes produces no byte
    do_reset();
    rand_img(1);
    send_frame(0, 16'd1, 1'b0, -1, 2);
    expect_end(0, "t4_glitch", 1'b1, 1'b0);

    // address wrap on the high base
    do_reset();
    rand_img(3);
    send_frame(1, 16'd3, 1'b0, -1, -1);
    expect_end(1, "t5_wrap", 1'b1, 1'b0);

    // count one past memory size
    do_reset();
    send_byte(1, 8'hA5, 1'b0);
    send_byte(1, 8'h01, 1'b0);
    send_byte(1, 8'h10, 1'b0);
    expect_end(1, "t5_cnt", 1'b0, 1'b1);

    // reset in the middle of a word
    do_reset();
    rand_img(2);
    send_byte(1, 8'hA5, 1'b0);
    send_byte(1, 8'h02, 1'b0);
    send_byte(1, 8'h00, 1'b0);
    push_exp(1, 0, img[0]);
    for (int k = 0; k < 4; k++) send_byte(1, img[0][8*k +: 8], 1'b0);
    for (int k = 0; k < 2; k++) send_byte(1, img[1][8*k +: 8], 1'b0);
    tick(5);
    chk("t6_pre_drain", expQ1.size(), 0);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_we", 32'(memWe[1]), 32'd0);
    chk("t6_addr", 32'(memAddr[1]), 32'd0);
    chk("t6_wdata", memWData[1], 32'd0);
    chk("t6_cpuRes", 32'(cpuRes[1]), 32'd1);
    chk("t6_done", 32'(loadDone[1]), 32'd0);
    chk("t6_err", 32'(loadErr[1]), 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    rand_img(3);
    send_frame(1, 16'd3, 1'b0, -1, -1);
    expect_end(1, "t6_reload", 1'b1, 1'b0);

    // random frames with junk prefixes
    for (int it = 0; it < 8; it++) begin
      do_reset();
      s = int'($urandom_range(1, 0));
      n = int'($urandom_range(4, 0));
      flip = ($urandom_range(2, 0) == 0);
      bad = ($urandom_range(3, 0) == 0 && n > 0) ?
            int'($urandom_range(4 * n - 1, 0)) : -1;
      rand_img(n);
      for (int j = 0; j < int'($urandom_range(2, 0)); j++) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        send_byte(s, g, 1'b0);
      end
      send_frame(s, 16'(n), flip, bad, -1);
      expect_end(s, "rand", (bad < 0) && !flip, (bad >= 0) || flip);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
